// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clk_div_bank divider bank.
// Build option: define SYNC_EN to add the bank-wide phase-align input.
package clk_div_pkg;

    // Default divisor/counter width used when the bank is not overridden.
    localparam int DIV_W = 32;

    // Width of a channel-select field for a bank of ch channels.
    function automatic int cw_of(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    // A reset divisor below 2 would leave every channel stopped; fall back to 2.
    function automatic int div_reset_value(input int d);
        return (d < 2) ? 2 : d;
    endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Divisor-write handshake bus of clk_div_bank (master drives, bank is slave).
interface clk_div_bank_if #(
    parameter int CH = 4,
    parameter int W  = clk_div_pkg::DIV_W
) ();
    localparam int CW = clk_div_pkg::cw_of(CH);

    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_ch;
    logic [W-1:0]  cfg_div;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor, and registered O_CLK/O_TICK.
// The sync input is tied low by the bank unless SYNC_EN is defined.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int W           = DIV_W,
    parameter int DIV_DEFAULT = 4
) (
    input  logic         I_CLK,
    input  logic         rst,
    input  logic         en,
    input  logic         wr,
    input  logic [W-1:0] wr_div,
    output logic         pending,
    output logic         O_CLK,
    output logic         O_TICK,
    input  logic         sync
);

    localparam logic [W-1:0] RST_DIV = W'(div_reset_value(DIV_DEFAULT));

    // Length of the low phase: ceil(d/2), computed without a wider adder.
    function automatic logic [W-1:0] half_ceil(input logic [W-1:0] d);
        return (d >> 1) + {{(W-1){1'b0}}, d[0]};
    endfunction

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] div_q, div_d;
    logic [W-1:0] shadow_q;
    logic         pend_q, pend_d;
    logic         clk_d, tick_d;
    logic         stopped, at_end, apply;

    always_comb begin
        stopped = (div_q < W'(2));
        at_end  = (cnt_q == (div_q - W'(1)));
        apply   = pend_q & (stopped | sync | (en & at_end));

        cnt_d  = cnt_q;
        div_d  = div_q;
        pend_d = pend_q;
        clk_d  = O_CLK;
        tick_d = 1'b0;

        if (apply) begin
            div_d  = shadow_q;
            pend_d = 1'b0;
        end

        if (stopped || sync) begin
            cnt_d = '0;
            clk_d = 1'b0;
        end else if (en) begin
            if (at_end) begin
                // Wrap: new period always starts in the low phase.
                cnt_d  = '0;
                clk_d  = 1'b0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
                clk_d = ((cnt_q + W'(1)) >= half_ceil(div_q));
            end
        end

        // Ready is low while pending, so a write never collides with an apply.
        if (wr) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge I_CLK or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            div_q  <= RST_DIV;
            pend_q <= 1'b0;
            O_CLK  <= 1'b0;
            O_TICK <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            pend_q <= pend_d;
            O_CLK  <= clk_d;
            O_TICK <= tick_d;
        end
    end

    // Shadow contents are only consumed while pending is set, so it needs no reset.
    always_ff @(posedge I_CLK) begin
        if (wr) begin
            shadow_q <= wr_div;
        end
    end

    assign pending = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of CH runtime-programmable clock dividers sharing one divisor-write port.
// Define SYNC_EN to add the sync input that phase-aligns all running channels.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int CH          = 4,
    parameter int W           = DIV_W,
    parameter int DIV_DEFAULT = 4
) (
    input  logic          I_CLK,
    input  logic          rst,
`ifdef SYNC_EN
    input  logic          sync,
`endif
    input  logic [CH-1:0] en,
    clk_div_bank_if.slave cfg,
    output logic [CH-1:0] O_CLK,
    output logic [CH-1:0] O_TICK
);

    logic [CH-1:0] pending;
    logic [CH-1:0] wr;
    logic          rdy;
    logic          sync_i;

`ifdef SYNC_EN
    assign sync_i = sync;
`else
    assign sync_i = 1'b0;
`endif

    // Out-of-range channel numbers are always ready and the write is dropped.
    always_comb begin
        rdy = 1'b1;
        for (int i = 0; i < CH; i++) begin
            if (32'(cfg.cfg_ch) == 32'(i)) begin
                rdy = ~pending[i];
            end
        end
    end

    assign cfg.cfg_ready = rdy;

    always_comb begin
        wr = '0;
        for (int i = 0; i < CH; i++) begin
            wr[i] = cfg.cfg_valid & rdy & (32'(cfg.cfg_ch) == 32'(i));
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_chan
        clk_div_chan #(
            .W           (W),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_chan (
            .I_CLK   (I_CLK),
            .rst     (rst),
            .en      (en[g]),
            .wr      (wr[g]),
            .wr_div  (cfg.cfg_div),
            .pending (pending[g]),
            .O_CLK   (O_CLK[g]),
            .O_TICK  (O_TICK[g]),
            .sync    (sync_i)
        );
    end

endmodule
